// File: rtl/mips_fetch_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
// Combinational definitions only; no latency.
// No flow control of its own.
package mips_fetch_pkg;

    localparam int          INSTR_W          = 32;
    localparam logic [31:0] PC_INC           = 32'd4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        RUN,
        WAIT,
        DROP
    } fetch_state_t;

    typedef struct packed {
        logic [31:0]        pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

    localparam int ENTRY_W = $bits(fetch_entry_t);

    function automatic logic [31:0] align_pc(input logic [31:0] pc);
        return pc & ~32'd3;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Instruction buffer holding {pc, instr} pairs between the memory and decode.
// One cycle from push to head visibility.
// Push is dropped when full; pop is ignored when empty; flush overrides both.
module fetch_fifo
    import mips_fetch_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CW    = $clog2(DEPTH) + 1
)(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               push,
    input  logic [ENTRY_W-1:0] push_dat,
    input  logic               pop,
    input  logic               flush,
    output logic [CW-1:0]      count,
    output logic [ENTRY_W-1:0] head
);
    localparam int            AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      rd_ptr;
    logic               do_push;
    logic               do_pop;

    assign do_pop  = pop  & ~flush & (count != '0);
    assign do_push = push & ~flush & (count < FULL_CNT);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: count gates every read of it.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_dat;
    end

endmodule

// File: rtl/imem_fetch_ctrl.sv
// Fetch sequencer: owns the PC, issues one imem read at a time, buffers words for decode.
// Same-cycle ack gives one fetch per cycle; a fetched word reaches decode the cycle after ack.
// Stops requesting when the buffer is full; redirects flush the buffer and drop in-flight data.
module imem_fetch_ctrl
    import mips_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
    parameter int          FIFO_DEPTH = 2
)(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    output logic [31:0] inst_data,
    output logic [31:0] inst_pc,
    input  logic        inst_ready,
    output logic        misalign_err
);
    localparam int            CW       = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

    fetch_state_t  state;
    logic [31:0]   fetch_pc;
    logic [31:0]   hold_addr;
    logic [CW-1:0] count;
    logic          push;
    logic          pop;
    fetch_entry_t  push_dat;
    fetch_entry_t  head;

    // Gating with rst_n drops the request the moment reset asserts.
    assign imem_req  = rst_n & ((state == RUN) ? ((count < FULL_CNT) & ~redirect_valid) : 1'b1);
    assign imem_addr = (state == RUN) ? fetch_pc : hold_addr;

    always_comb begin
        push = 1'b0;
        case (state)
            RUN:     push = imem_req & imem_ack;
            WAIT:    push = imem_ack & ~redirect_valid;
            default: push = 1'b0;
        endcase
    end

    assign push_dat.pc    = imem_addr;
    assign push_dat.instr = imem_rdata;

    assign inst_valid = (count != '0);
    assign pop        = inst_valid & inst_ready;
    assign inst_data  = head.instr;
    assign inst_pc    = head.pc;

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .CW    (CW)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (push),
        .push_dat (push_dat),
        .pop      (pop),
        .flush    (redirect_valid),
        .count    (count),
        .head     (head)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= RUN;
            fetch_pc     <= align_pc(RESET_PC);
            hold_addr    <= align_pc(RESET_PC);
            misalign_err <= 1'b0;
        end else begin
            misalign_err <= redirect_valid & (redirect_pc[1:0] != 2'b00);

            if (redirect_valid)
                fetch_pc <= align_pc(redirect_pc);
            else if (push)
                fetch_pc <= fetch_pc + PC_INC;

            case (state)
                RUN: begin
                    // Latch the issued address so a later redirect cannot disturb the bus.
                    if (imem_req) begin
                        hold_addr <= fetch_pc;
                        if (!imem_ack) state <= WAIT;
                    end
                end
                WAIT: begin
                    if (imem_ack)            state <= RUN;
                    else if (redirect_valid) state <= DROP;
                end
                DROP: begin
                    if (imem_ack) state <= RUN;
                end
                default: state <= RUN;
            endcase
        end
    end

endmodule
